// File: rtl/sumador_serie_ctrl.sv
// sumador_serie_ctrl: bit-serial N-bit add sequencer driving one external 1-bit full adder
module sumador_serie_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         co,
    output logic         add_a,
    output logic         add_b,
    output logic         add_ci,
    input  logic         add_s,
    input  logic         add_co
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SUMA, FIN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_a_q, sr_a_d, sr_b_q, sr_b_d, sr_res_q, sr_res_d, s_q, s_d;
    logic           carry_q, carry_d, co_q, co_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   res_next;
    logic           last;

    // Sum bits enter at the MSB so after N shifts bit 0 holds the first (LSB) sum.
    assign res_next = N'({add_s, sr_res_q} >> 1);
    assign last     = (cnt_q == CW'(N - 1));
    assign busy     = (state_q == SUMA);
    assign done     = (state_q == FIN);
    assign add_a    = busy & sr_a_q[0];
    assign add_b    = busy & sr_b_q[0];
    assign add_ci   = busy & carry_q;
    assign s        = s_q;
    assign co       = co_q;

    always_comb begin
        state_d  = state_q;
        sr_a_d   = sr_a_q;
        sr_b_d   = sr_b_q;
        sr_res_d = sr_res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        co_d     = co_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SUMA;
                sr_a_d  = a;
                sr_b_d  = b;
                carry_d = ci_in;
                cnt_d   = '0;
            end
            SUMA: begin
                sr_res_d = res_next;
                carry_d  = add_co;
                sr_a_d   = sr_a_q >> 1;
                sr_b_d   = sr_b_q >> 1;
                cnt_d    = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    state_d = FIN;
                    s_d     = res_next;
                    co_d    = add_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_a_q   <= '0;
            sr_b_q   <= '0;
            sr_res_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            co_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_a_q   <= sr_a_d;
            sr_b_q   <= sr_b_d;
            sr_res_q <= sr_res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            co_q     <= co_d;
        end
    end
endmodule
